// File: rtl/dll_code_ctrl.sv
// Delay-code controller for the FMDLL loop: M/N frame counters, a binary-search
// (SAR) acquisition of the delay code, then +/-1 tracking with lock detection.
module dll_code_ctrl #(
  parameter int M_W      = 2,
  parameter int N_W      = 4,
  parameter int Q_W      = 10,
  parameter int LOCK_CNT = 4
) (
  input  logic           clk_ext,
  input  logic           Reset_DLL,
  input  logic           enable,
  input  logic [M_W-1:0] M,
  input  logic [N_W-1:0] N,
  input  logic           COMP,
  output logic [M_W-1:0] M_counter,
  output logic [N_W-1:0] N_counter,
  output logic [Q_W-1:0] Q,
  output logic [Q_W-1:0] Q_next,
  output logic           Reset_PD,
  output logic           locked,
  output logic           busy
);

  localparam int B_W = (Q_W > 1) ? $clog2(Q_W) : 1;
  localparam int R_W = $clog2(LOCK_CNT + 1);
  localparam logic [Q_W-1:0] Q_MAX    = '1;
  localparam logic [Q_W-1:0] Q_MID    = Q_W'(1) << (Q_W - 1);
  localparam logic [R_W-1:0] LOCK_LIM = R_W'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, SAR, TRACK} state_t;

  state_t         state, state_next;
  logic [B_W-1:0] bit_idx;
  logic           armed, have_dir, last_dir;
  logic [R_W-1:0] rev_cnt, same_cnt, rev_nx, same_nx;
  logic [M_W-1:0] m_lim;
  logic [N_W-1:0] n_lim;
  logic           frame_end, eval;
  logic [Q_W-1:0] q_up, q_dn, q_new, q_nudge, sar_bit;

  // A zero frame count would stall the counters, so it behaves like 1.
  assign m_lim     = (M == '0) ? M_W'(1) : M;
  assign n_lim     = (N == '0) ? N_W'(1) : N;
  assign frame_end = (M_counter == m_lim) && (N_counter == n_lim);
  assign eval      = armed && (M_counter == M_W'(1)) && (N_counter == N_W'(1));
  assign busy      = (state == SAR);

  assign q_up    = (Q == Q_MAX) ? Q : Q + Q_W'(1);
  assign q_dn    = (Q == '0) ? Q : Q - Q_W'(1);
  assign q_new   = (state == SAR) ? (COMP ? Q_next : Q) : (COMP ? q_up : q_dn);
  assign q_nudge = (q_new == Q_MAX) ? q_new - Q_W'(1) : q_new + Q_W'(1);
  assign sar_bit = Q_W'(1) << (bit_idx - B_W'(1));

  always_ff @(posedge clk_ext) begin
    if (Reset_DLL) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = SAR;
      SAR:     if (eval && bit_idx == '0) state_next = TRACK;
      TRACK:   state_next = TRACK;
      default: state_next = IDLE;
    endcase
    if (!enable) state_next = IDLE;
  end

  // The first tracking step only records a direction; afterwards reversals
  // build toward lock and a long one-way run tears it down again.
  always_comb begin
    rev_nx  = rev_cnt;
    same_nx = same_cnt;
    if (have_dir) begin
      if (COMP != last_dir) begin
        rev_nx  = (rev_cnt >= LOCK_LIM) ? rev_cnt : rev_cnt + R_W'(1);
        same_nx = '0;
      end else begin
        same_nx = same_cnt + R_W'(1);
        if (same_nx >= LOCK_LIM) begin
          rev_nx  = '0;
          same_nx = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_ext) begin
    if (Reset_DLL || !enable || state == IDLE) begin
      M_counter <= M_W'(1);
      N_counter <= N_W'(1);
      Q         <= '0;
      Q_next    <= Q_MID;
      Reset_PD  <= 1'b1;
      locked    <= 1'b0;
      armed     <= 1'b0;
      bit_idx   <= B_W'(Q_W - 1);
      have_dir  <= 1'b0;
      last_dir  <= 1'b0;
      rev_cnt   <= '0;
      same_cnt  <= '0;
    end else begin
      Reset_PD <= 1'b0;
      // An outer counter left beyond a shrunken limit wraps on its own.
      if (N_counter >= n_lim) begin
        N_counter <= N_W'(1);
        M_counter <= (M_counter >= m_lim) ? M_W'(1) : M_counter + M_W'(1);
      end else begin
        N_counter <= N_counter + N_W'(1);
        if (M_counter > m_lim) M_counter <= M_W'(1);
      end
      if (frame_end) armed <= 1'b1;
      if (eval) begin
        Q <= q_new;
        if (state == SAR) begin
          bit_idx <= bit_idx - B_W'(1);
          Q_next  <= (bit_idx == '0) ? q_nudge : (q_new | sar_bit);
        end else begin
          Q_next   <= q_nudge;
          have_dir <= 1'b1;
          last_dir <= COMP;
          rev_cnt  <= rev_nx;
          same_cnt <= same_nx;
          locked   <= (rev_nx >= LOCK_LIM);
        end
      end
    end
  end

endmodule

// File: tb/tb_dll_code_ctrl.sv
// Directed bench for dll_code_ctrl: a vector table for acquisition with a
// one-cycle frame, plus hand sequences for frame timing, lock and aborts.
module tb_dll_code_ctrl;

  logic       clk = 1'b0;
  logic       reset_dll, enable, comp_man, comp_auto, comp;
  logic [1:0] m_in, m_cnt;
  logic [3:0] n_in, n_cnt;
  logic [9:0] q, q_next;
  logic       reset_pd, locked, busy;
  int         checks = 0;
  int         failures = 0;

  typedef struct {
    logic       en;
    logic [1:0] m;
    logic [3:0] n;
    logic       cmp;
    int         cycles;
    int         q;
    int         qn;
    logic       busy;
    logic       rpd;
    logic       lck;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  // The phase detector is modelled as a fixed threshold on the candidate code.
  assign comp = comp_auto ? (q_next <= 10'd600) : comp_man;

  dll_code_ctrl dut (
    .clk_ext   (clk),
    .Reset_DLL (reset_dll),
    .enable    (enable),
    .M         (m_in),
    .N         (n_in),
    .COMP      (comp),
    .M_counter (m_cnt),
    .N_counter (n_cnt),
    .Q         (q),
    .Q_next    (q_next),
    .Reset_PD  (reset_pd),
    .locked    (locked),
    .busy      (busy)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    enable   = v.en;
    m_in     = v.m;
    n_in     = v.n;
    comp_man = v.cmp;
    tick(v.cycles);
  endtask

  task automatic do_reset();
    reset_dll = 1'b1;
    enable    = 1'b0;
    comp_auto = 1'b0;
    comp_man  = 1'b0;
    m_in      = 2'd1;
    n_in      = 4'd1;
    tick(2);
    reset_dll = 1'b0;
  endtask

  initial begin
    int exp_q[9];
    logic exp_lck[9];
    logic dir_seq[9];

    vecs[0] = '{1'b1, 2'd1, 4'd1, 1'b1, 1, 0,    512,  1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 2'd1, 4'd1, 1'b1, 1, 0,    512,  1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 2'd1, 4'd1, 1'b1, 1, 512,  768,  1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 2'd1, 4'd1, 1'b1, 1, 768,  896,  1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 2'd1, 4'd1, 1'b1, 8, 1023, 1022, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 2'd1, 4'd1, 1'b1, 3, 1023, 1022, 1'b0, 1'b0, 1'b0};

    do_reset();
    check_output("rst_q", q, 0);
    check_output("rst_qnext", q_next, 512);
    check_output("rst_mcnt", m_cnt, 1);
    check_output("rst_ncnt", n_cnt, 1);
    check_output("rst_rpd", reset_pd, 1);
    check_output("rst_locked", locked, 0);
    check_output("rst_busy", busy, 0);

    // COMP tied high with a one-cycle frame: SAR climbs to the top and saturates.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d_q", i), q, vecs[i].q);
      check_output($sformatf("vec%0d_qnext", i), q_next, vecs[i].qn);
      check_output($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      check_output($sformatf("vec%0d_rpd", i), reset_pd, vecs[i].rpd);
      check_output($sformatf("vec%0d_locked", i), locked, vecs[i].lck);
    end

    // Threshold search with M=2, N=3: evals land on edges 7, 13, ..., 61.
    do_reset();
    m_in = 2'd2; n_in = 4'd3; comp_auto = 1'b1; enable = 1'b1;
    tick(8);
    check_output("sar6_first_q", q, 512);
    check_output("sar6_first_qnext", q_next, 768);
    tick(1);
    check_output("sar6_stable_q", q, 512);
    check_output("sar6_stable_qnext", q_next, 768);
    tick(53);
    check_output("sar6_final_q", q, 600);
    check_output("sar6_final_qnext", q_next, 601);
    check_output("sar6_final_busy", busy, 0);

    // Lock: alternate direction from the bottom, then run upward four times.
    do_reset();
    enable = 1'b1;
    tick(12);
    check_output("lock_sar_q", q, 0);
    check_output("lock_sar_qnext", q_next, 1);
    dir_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_q   = '{1, 0, 1, 0, 1, 2, 3, 4, 5};
    exp_lck = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      comp_man = dir_seq[i];
      tick(1);
      check_output($sformatf("lock%0d_q", i), q, exp_q[i]);
      check_output($sformatf("lock%0d_locked", i), locked, exp_lck[i]);
    end
    check_output("lock_end_qnext", q_next, 6);

    reset_dll = 1'b1;
    tick(1);
    check_output("rstovr_q", q, 0);
    check_output("rstovr_busy", busy, 0);
    check_output("rstovr_rpd", reset_pd, 1);
    reset_dll = 1'b0;

    // Abort after four SAR steps (bit index 5 pending).
    do_reset();
    comp_man = 1'b1; enable = 1'b1;
    tick(6);
    check_output("abort_pre_q", q, 960);
    check_output("abort_pre_qnext", q_next, 992);
    check_output("abort_pre_rpd", reset_pd, 0);
    enable = 1'b0;
    tick(1);
    check_output("abort_q", q, 0);
    check_output("abort_qnext", q_next, 512);
    check_output("abort_mcnt", m_cnt, 1);
    check_output("abort_ncnt", n_cnt, 1);
    check_output("abort_rpd", reset_pd, 1);
    check_output("abort_locked", locked, 0);
    check_output("abort_busy", busy, 0);

    // Zero frame counts behave like one.
    do_reset();
    m_in = 2'd0; n_in = 4'd0; comp_man = 1'b1; enable = 1'b1;
    tick(2);
    check_output("zero_pre_q", q, 0);
    tick(1);
    check_output("zero_eval_q", q, 512);

    // Shrink N from 8 to 3 while N_counter sits at 6.
    do_reset();
    m_in = 2'd2; n_in = 4'd8; comp_man = 1'b1; enable = 1'b1;
    tick(6);
    check_output("shrink_pre_ncnt", n_cnt, 6);
    check_output("shrink_pre_mcnt", m_cnt, 1);
    n_in = 4'd3;
    tick(1);
    check_output("shrink_ncnt", n_cnt, 1);
    check_output("shrink_mcnt", m_cnt, 2);
    tick(3);
    check_output("shrink_noeval_q", q, 0);
    tick(1);
    check_output("shrink_eval1_q", q, 512);
    tick(5);
    check_output("shrink_nodup_q", q, 512);
    tick(1);
    check_output("shrink_eval2_q", q, 768);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
